// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, widths and PC helper for the fetch controller
package fetch_pkg;
  localparam int INSTR_W = 32;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_t;
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: decode handshake plus instruction memory port of the fetch stage
interface fetch_ctrl_if;
  import fetch_pkg::*;
  logic stall;
  logic redirect;
  logic [31:0] redirect_pc;
  logic imem_gnt;
  logic imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic imem_req;
  logic [31:0] imem_addr;
  logic instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [31:0] instr_pc;
  modport master (
    output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    input imem_req, imem_addr, instr_valid, instr, instr_pc
  );
  modport slave (
    input stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer parking a response that arrived while decode was stalled
module fetch_skid
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_data,
  input  logic [31:0]        i_pc,
  output logic [INSTR_W-1:0] o_data,
  output logic [31:0]        o_pc,
  output logic               o_valid
);
  logic [INSTR_W-1:0] r_data;
  logic [31:0] r_pc;
  logic r_valid;
  always_ff @(posedge clk)
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_pc <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data <= i_data;
      r_pc <= i_pc;
    end else if (i_unload)
      r_valid <= 1'b0;
  assign o_data = r_data;
  assign o_pc = r_pc;
  assign o_valid = r_valid;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with redirect and decode back-pressure
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_ctrl_if.slave bus
);
  fetch_state_t r_state;
  logic [31:0] r_pc;
  logic r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0] r_instr_pc;
  logic w_req, w_slot_free, w_consume, w_rv_wait;
  logic w_skid_load, w_skid_unload, w_skid_valid;
  logic [INSTR_W-1:0] w_skid_data;
  logic [31:0] w_skid_pc;
  assign w_req = !rst && r_state == REQ && !(r_instr_valid && bus.stall) && !bus.redirect;
  assign w_slot_free = !r_instr_valid || !bus.stall;
  assign w_consume = r_instr_valid && !bus.stall;
  assign w_rv_wait = r_state == WAIT && bus.imem_rvalid;
  assign w_skid_load = !bus.redirect && w_rv_wait && !w_slot_free;
  assign w_skid_unload = !bus.redirect && r_state == HOLD && !bus.stall;
  fetch_skid u_skid (
    .clk(clk),
    .rst(rst),
    .i_load(w_skid_load),
    .i_unload(w_skid_unload),
    .i_clear(bus.redirect),
    .i_data(bus.imem_rdata),
    .i_pc(r_pc),
    .o_data(w_skid_data),
    .o_pc(w_skid_pc),
    .o_valid(w_skid_valid)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= REQ;
      r_pc <= align_pc(RESET_PC);
      r_instr_valid <= 1'b0;
      r_instr <= '0;
      r_instr_pc <= '0;
    end else if (bus.redirect) begin
      r_pc <= align_pc(bus.redirect_pc);
      r_instr_valid <= 1'b0;
      // an accepted request still owes one response, which DRAIN swallows
      r_state <= (((r_state == WAIT || r_state == DRAIN) && !bus.imem_rvalid) ||
                  (w_req && bus.imem_gnt)) ? DRAIN : REQ;
    end else begin
      if (w_consume) r_instr_valid <= 1'b0;
      case (r_state)
        REQ: if (w_req && bus.imem_gnt) r_state <= WAIT;
        WAIT:
          if (bus.imem_rvalid) begin
            r_pc <= r_pc + 32'd4;
            r_state <= w_slot_free ? REQ : HOLD;
            if (w_slot_free) begin
              r_instr <= bus.imem_rdata;
              r_instr_pc <= r_pc;
              r_instr_valid <= 1'b1;
            end
          end
        HOLD:
          if (!bus.stall) begin
            r_instr <= w_skid_data;
            r_instr_pc <= w_skid_pc;
            r_instr_valid <= w_skid_valid;
            r_state <= REQ;
          end
        DRAIN: if (bus.imem_rvalid) r_state <= REQ;
        default: r_state <= REQ;
      endcase
    end
  assign bus.imem_req = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr = r_instr;
  assign bus.instr_pc = r_instr_pc;
  a_rvalid_protocol: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rvalid && (r_state == REQ || r_state == HOLD)));
endmodule
